// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the RAM request/status handshake.
// The RAM responder and the memory controller both import this.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  localparam int RAM_LAT_W = 4;

endpackage

// File: rtl/ram_responder.sv
// Behavioural word RAM answering controller requests with a ramstate_t status
// after a programmable number of wait cycles.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT = 2,
  parameter int AW  = 10
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int DEPTH = 1 << AW;
  localparam logic [RAM_LAT_W-1:0] LAT_CNT = RAM_LAT_W'(LAT);

  word_t                mem [DEPTH];
  logic [RAM_LAT_W-1:0] cnt_reg;
  logic [RAM_LAT_W-1:0] cnt_next;
  logic [RAM_LAT_W-1:0] cnt_eff;
  logic                 prev_valid_reg;
  logic                 prev_valid_next;
  word_t                prev_addr_reg;
  logic [1:0]           prev_op_reg;
  logic [1:0]           op;
  logic                 valid;
  logic                 err;
  logic                 same;
  logic                 mem_we;
  logic [AW-1:0]        idx;

  assign op    = {ramREN, ramWEN};
  assign valid = ramREN | ramWEN;
  assign idx   = ramaddr[AW+1:2];

  // Anything outside the array, misaligned, or asking for both ops is refused.
  assign err = valid && ((ramREN && ramWEN) ||
                         (ramaddr[1:0] != 2'b00) ||
                         ((ramaddr >> (AW + 2)) != '0));

  // The wait count only carries over while the exact same request is held.
  assign same    = valid && prev_valid_reg && (ramaddr == prev_addr_reg) && (op == prev_op_reg);
  assign cnt_eff = same ? cnt_reg : '0;

  always_comb begin
    ramstate        = FREE;
    ramload         = '0;
    cnt_next        = '0;
    prev_valid_next = valid;
    mem_we          = 1'b0;
    if (err) begin
      ramstate = ERROR;
    end else if (!valid) begin
      ramstate = FREE;
    end else if (cnt_eff == LAT_CNT) begin
      // A request held past ACCESS must be seen as new, hence the history drop.
      ramstate        = ACCESS;
      prev_valid_next = 1'b0;
      if (ramREN) begin
        ramload = mem[idx];
      end else begin
        mem_we = 1'b1;
      end
    end else begin
      ramstate = BUSY;
      cnt_next = cnt_eff + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_reg        <= '0;
      prev_valid_reg <= 1'b0;
      prev_addr_reg  <= '0;
      prev_op_reg    <= '0;
    end else begin
      cnt_reg        <= cnt_next;
      prev_valid_reg <= prev_valid_next;
      prev_addr_reg  <= ramaddr;
      prev_op_reg    <= op;
    end
  end

  // Storage is deliberately left unreset; contents are undefined until written.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx] <= ramstore;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Drives three responders (LAT 2, 0, 3) with one shared request stream and
// compares status and read data against a request-age model of the RAM.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int AW = 10;
  localparam int NI = 3;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     load [NI];
  ramstate_t st   [NI];

  int        lat_v [NI];
  int        start_c [NI];
  bit        last_busy [NI];
  ramstate_t exp_st [NI];
  word_t     mem_m [int];
  bit        last_valid;
  word_t     last_addr;
  logic [1:0] last_op;
  int        cyc;
  int        checks;
  int        passes;

  always #5 CLK = ~CLK;

  ram_responder #(.LAT(2), .AW(AW)) u_lat2 (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(load[0]), .ramstate(st[0])
  );
  ram_responder #(.LAT(0), .AW(AW)) u_lat0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(load[1]), .ramstate(st[1])
  );
  ram_responder #(.LAT(3), .AW(AW)) u_lat3 (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(load[2]), .ramstate(st[2])
  );

  function automatic int key_of(input int k, input word_t a);
    return k * 4096 + int'((a >> 2) & 32'h3FF);
  endfunction

  // One bus cycle: drive at posedge+1, check at the falling edge, then
  // advance the model across the rising edge.
  task automatic step(input bit r, input bit w, input word_t a, input word_t d,
                      input bit rst_l, input string tag);
    bit    valid;
    bit    err;
    bit    same_in;
    word_t exp_load;
    bit    load_known;
    ramREN   = r;
    ramWEN   = w;
    ramaddr  = a;
    ramstore = d;
    nRST     = rst_l;
    #4;
    valid   = r | w;
    err     = valid && ((r && w) || (a[1:0] != 2'b00) || (a >= (32'd1 << (AW + 2))));
    same_in = valid && last_valid && (a == last_addr) && ({r, w} == last_op);
    for (int k = 0; k < NI; k++) begin
      // A request's age restarts whenever it changes, follows a non-waiting
      // cycle, or is seen under reset.
      if (!same_in || !last_busy[k] || !rst_l) start_c[k] = cyc;
      if (err)                           exp_st[k] = ERROR;
      else if (!valid)                   exp_st[k] = FREE;
      else if (cyc - start_c[k] == lat_v[k]) exp_st[k] = ACCESS;
      else                               exp_st[k] = BUSY;
      checks++;
      assert (st[k] === exp_st[k]) passes++;
      else $error("FAIL %s state lat=%0d cyc=%0d: got %s want %s",
                  tag, lat_v[k], cyc, st[k].name(), exp_st[k].name());
      load_known = 1'b1;
      exp_load   = '0;
      if (exp_st[k] == ACCESS && r) begin
        if (mem_m.exists(key_of(k, a))) exp_load = mem_m[key_of(k, a)];
        else load_known = 1'b0;
      end
      if (load_known) begin
        checks++;
        assert (load[k] === exp_load) passes++;
        else $error("FAIL %s load lat=%0d cyc=%0d addr=%h: got %h want %h",
                    tag, lat_v[k], cyc, a, load[k], exp_load);
      end
    end
    @(posedge CLK);
    for (int k = 0; k < NI; k++) begin
      if (exp_st[k] == ACCESS && w) mem_m[key_of(k, a)] = d;
      last_busy[k] = (exp_st[k] == BUSY) && rst_l;
    end
    last_valid = valid;
    last_addr  = a;
    last_op    = {r, w};
    $display("cyc %0d %s ren=%0b wen=%0b addr=%h st=%s/%s/%s", cyc, tag, r, w, a,
             exp_st[0].name(), exp_st[1].name(), exp_st[2].name());
    cyc++;
    #1;
  endtask

  task automatic hold(input bit r, input bit w, input word_t a, input word_t d,
                      input int n, input string tag);
    for (int i = 0; i < n; i++) step(r, w, a, d, 1'b1, tag);
  endtask

  initial begin
    lat_v[0] = 2; lat_v[1] = 0; lat_v[2] = 3;
    for (int k = 0; k < NI; k++) begin
      start_c[k]   = 0;
      last_busy[k] = 1'b0;
      exp_st[k]    = FREE;
    end
    checks = 0; passes = 0; cyc = 0;
    last_valid = 1'b0; last_addr = '0; last_op = '0;
    nRST = 1'b0; ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
    @(posedge CLK); #1;

    step(0, 0, 32'h0, 32'h0, 1'b0, "reset");
    step(0, 0, 32'h0, 32'h0, 1'b0, "reset");
    hold(0, 0, 32'h0, 32'h0, 1, "idle");

    hold(0, 1, 32'h40, 32'hDEADBEEF, 4, "wr40");
    hold(0, 0, 32'h0, 32'h0, 1, "idle");
    hold(1, 0, 32'h40, 32'h0, 4, "rd40");

    hold(0, 1, 32'h44, 32'h44444444, 4, "wr44");
    hold(1, 0, 32'h40, 32'h0, 1, "rd40a");
    hold(1, 0, 32'h44, 32'h0, 4, "rd44");

    hold(1, 1, 32'h0, 32'h0, 2, "err_rw");
    hold(1, 0, 32'h41, 32'h0, 2, "err_mis");
    hold(1, 0, 32'h1000, 32'h0, 2, "err_range");
    hold(0, 1, 32'h0, 32'h0, 4, "wr0");
    hold(1, 0, 32'h40, 32'h0, 4, "rd40b");
    hold(1, 0, 32'h44, 32'h0, 4, "rd44b");

    hold(0, 1, 32'h8, 32'h12345678, 3, "wr8");
    hold(1, 0, 32'h8, 32'h0, 4, "rd8");

    hold(0, 1, 32'h10, 32'h0BADF00D, 4, "pre10");
    hold(0, 0, 32'h0, 32'h0, 1, "idle");
    step(0, 1, 32'h10, 32'hAAAA5555, 1'b1, "wr10");
    step(0, 1, 32'h10, 32'hAAAA5555, 1'b1, "wr10");
    step(0, 1, 32'h10, 32'hAAAA5555, 1'b0, "wr10_rst");
    hold(0, 0, 32'h0, 32'h0, 1, "post_rst");
    hold(1, 0, 32'h10, 32'h0, 4, "rd10");

    for (int i = 0; i < 30; i++) begin
      bit    r;
      bit    w;
      word_t a;
      word_t d;
      int    sel;
      sel = int'($urandom_range(0, 9));
      r   = (sel < 5);
      w   = (sel >= 5 && sel < 9) || (sel == 4 && $urandom_range(0, 1) == 1);
      a   = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
      d   = $urandom;
      hold(r, w, a, d, int'($urandom_range(1, 5)), "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
